signed_digit_display: RTL and testbench

- Downstream consumer of the 3-bit negator stage. It takes that stage's 4-bit two's-complement result {K,L,M,N} and shows it on the board's 4-digit seven-segment display.
- The input is combinational logic driven by slide switches, so it is synchronised and stability-filtered before display.
- Output is sign and magnitude: digit 1 shows "-" for negative values, digit 0 shows the magnitude 0–8, and digits 2–3 stay dark.
- Anode scanning is time-multiplexed.

---
 rtl/signed_digit_display.sv | 149 ++++++++++++++
 tb/tb_signed_digit_display.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_digit_display.sv
// signed_digit_display: filtered sign/magnitude view of a 4-bit
// two's-complement value on a 4-digit multiplexed seven-segment display.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   value_in   4-bit two's-complement input (bit 3 = sign)
//   blank      forces all anodes off; scan and filter keep running
//   disp_value accepted (stable) input value
//   seg        cathodes {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low, held off
//   an         anodes, active-low, an[0] = rightmost digit
module signed_digit_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value_in,
  input  logic       blank,
  output logic [3:0] disp_value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DIV_W =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int STB_W =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(REFRESH_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST =
    STB_W'(STABLE_CYCLES - 1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       cand_q, cand_d;
  logic [STB_W-1:0] stab_q, stab_d;
  logic [3:0]       disp_q, disp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       neg;
  logic [3:0] mag;
  logic [6:0] glyph;

  // Input path: two-flop synchroniser, then a stability filter.
  // The counter saturates at its last value once a value is accepted.
  always_comb begin
    sync1_d = value_in;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    disp_d  = disp_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = '0;
    end else if (stab_q == STB_LAST) begin
      disp_d = cand_q;
    end else begin
      stab_d = stab_q + STB_W'(1);
    end
  end

  // Scan: each digit slot lasts REFRESH_DIV cycles.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Magnitude: -8 (4'b1000) negates to 4'b1000, read as 8.
  always_comb begin
    neg = disp_q[3];
    mag = neg ? (~disp_q + 4'd1) : disp_q;
  end

  always_comb begin
    case (mag)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      default: glyph = 7'h7F;
    endcase
  end

  // Slots 2 and 3 stay dark so the duty cycle is a fixed 1/4.
  always_comb begin
    seg_d = 7'h7F;
    an_d  = 4'hF;
    if (!blank) begin
      unique case (1'b1)
        (idx_q == 2'd0): begin
          an_d  = 4'b1110;
          seg_d = glyph;
        end
        (idx_q == 2'd1): begin
          if (neg) begin
            an_d  = 4'b1101;
            seg_d = 7'h3F;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      disp_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      disp_q  <= disp_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign disp_value = disp_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = 1'b1;

endmodule

// File: tb/tb_signed_digit_display.sv
// tb_signed_digit_display: scoreboard bench for signed_digit_display
// with REFRESH_DIV=4, STABLE_CYCLES=3.
module tb_signed_digit_display;

  localparam int RD = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] value_in;
  logic       blank;
  logic [3:0] disp_value;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  signed_digit_display #(
    .REFRESH_DIV  (RD),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .blank     (blank),
    .disp_value(disp_value),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  logic [6:0] glyph_t [0:8] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00
  };

  logic [3:0] m_s1, m_s2, m_cand, m_disp;
  int         m_cnt, m_div, m_idx;
  logic [6:0] m_seg;
  logic [3:0] m_an;

  // Advance one clock edge, update the reference model with the
  // inputs seen at that edge and queue the expected outputs.
  task automatic tick();
    logic [6:0] ns;
    logic [3:0] na;
    int         v;
    @(posedge clk);
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_cand = 0; m_disp = 0;
      m_cnt = 0; m_div = 0; m_idx = 0;
      m_seg = 7'h7F; m_an = 4'hF;
    end else begin
      v = $signed(m_disp);
      if (v < 0) v = -v;
      ns = 7'h7F;
      na = 4'hF;
      if (!blank) begin
        if (m_idx == 0) begin
          na = 4'b1110;
          ns = glyph_t[v];
        end else if (m_idx == 1 && m_disp[3]) begin
          na = 4'b1101;
          ns = 7'h3F;
        end
      end
      m_seg = ns;
      m_an  = na;
      if (m_s2 != m_cand) begin
        m_cand = m_s2;
        m_cnt  = 0;
      end else if (m_cnt == SC - 1) begin
        m_disp = m_cand;
      end else begin
        m_cnt++;
      end
      m_s2 = m_s1;
      m_s1 = value_in;
      if (m_div == RD - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_div++;
      end
    end
    exp_q.push_back({m_disp, m_seg, m_an, 1'b1});
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    blank    = 1'b0;
    value_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_reset got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      n_tests++;
      if ({seg, an, dp, disp_value} !== {7'h7F, 4'hF, 1'b1, 4'h0}) begin
        n_fail++;
        $display("FAIL reset_hold seg=%h an=%h dp=%b dv=%h want 7f f 1 0",
                 seg, an, dp, disp_value);
      end
    end
    reset = 1'b0;
    tick();
    exp_w = exp_q.pop_front();
    n_tests++;
    if ({disp_value, seg, an, dp} !== exp_w) begin
      n_fail++;
      $display("FAIL sb_release got %h want %h",
               {disp_value, seg, an, dp}, exp_w);
    end
    n_tests++;
    if ({an, seg} !== {4'b1110, 7'h40}) begin
      n_fail++;
      $display("FAIL release_slot0 an=%b seg=%h want 1110 40", an, seg);
    end
  endtask

  // value_in = -1 has been held since the release edge (E1).
  task automatic test_negative();
    int n0, n1, ndark;
    for (int e = 2; e <= 6; e++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_neg got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (e == 5) begin
        n_tests++;
        if (disp_value !== 4'h0) begin
          n_fail++;
          $display("FAIL neg_early dv=%h want 0 at E5", disp_value);
        end
      end
      if (e == 6) begin
        n_tests++;
        if (disp_value !== 4'hF) begin
          n_fail++;
          $display("FAIL neg_accept dv=%h want f at E6", disp_value);
        end
      end
    end
    n0 = 0; n1 = 0; ndark = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_neg_scan got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (an == 4'b1110) begin
        n0++;
        n_tests++;
        if (seg !== 7'h79) begin
          n_fail++;
          $display("FAIL neg_slot0 seg=%h want 79", seg);
        end
      end else if (an == 4'b1101) begin
        n1++;
        n_tests++;
        if (seg !== 7'h3F) begin
          n_fail++;
          $display("FAIL neg_slot1 seg=%h want 3f", seg);
        end
      end else begin
        ndark++;
      end
    end
    n_tests++;
    if ({n0, n1, ndark} !== {32'd4, 32'd4, 32'd8}) begin
      n_fail++;
      $display("FAIL neg_duty n0=%0d n1=%0d dark=%0d want 4 4 8",
               n0, n1, ndark);
    end
  endtask

  task automatic test_minimum();
    int n1;
    value_in = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_min got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
    end
    n_tests++;
    if (disp_value !== 4'h8) begin
      n_fail++;
      $display("FAIL min_accept dv=%h want 8", disp_value);
    end
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_min_scan got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (an == 4'b1110) begin
        n_tests++;
        if (seg !== 7'h00) begin
          n_fail++;
          $display("FAIL min_slot0 seg=%h want 00", seg);
        end
      end
      if (an == 4'b1101) n1++;
    end
    n_tests++;
    if (n1 != 4) begin
      n_fail++;
      $display("FAIL min_minus cycles=%0d want 4", n1);
    end
    value_in = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_pos got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
    end
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_pos_scan got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (an == 4'b1110) begin
        n_tests++;
        if (seg !== 7'h12) begin
          n_fail++;
          $display("FAIL pos_slot0 seg=%h want 12", seg);
        end
      end
      if (an == 4'b1101) n1++;
    end
    n_tests++;
    if (n1 != 0) begin
      n_fail++;
      $display("FAIL pos_slot1_dark lit=%0d want 0", n1);
    end
  endtask

  task automatic test_glitch();
    value_in = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_gl_set got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
    end
    n_tests++;
    if (disp_value !== 4'h3) begin
      n_fail++;
      $display("FAIL gl_base dv=%h want 3", disp_value);
    end
    value_in = 4'b1101;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) value_in = 4'b0011;
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_glitch got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      n_tests++;
      if (disp_value !== 4'h3) begin
        n_fail++;
        $display("FAIL gl_reject dv=%h want 3", disp_value);
      end
    end
    value_in = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_gl_hold got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
    end
    n_tests++;
    if (disp_value !== 4'hD) begin
      n_fail++;
      $display("FAIL gl_accept dv=%h want d", disp_value);
    end
  endtask

  // disp_value = D (negative), so slot 1 is lit and distinguishable.
  task automatic test_scan_blank();
    logic [3:0] prev, want;
    bit         found;
    prev  = an;
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_align got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (prev != 4'b1110 && an == 4'b1110) found = 1;
      prev = an;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL scan_align no slot0 start in 24 cycles an=%b", an);
    end
    for (int p = 1; p < 16; p++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_scan got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      want = (p < 4) ? 4'b1110 : (p < 8) ? 4'b1101 : 4'hF;
      n_tests++;
      if (an !== want) begin
        n_fail++;
        $display("FAIL scan_order p=%0d an=%b want %b", p, an, want);
      end
    end
    for (int p = 0; p < 16; p++) begin
      if (p == 2) blank = 1'b1;
      if (p == 7) blank = 1'b0;
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_blank got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (p >= 2 && p < 7) begin
        n_tests++;
        if ({an, seg} !== {4'hF, 7'h7F}) begin
          n_fail++;
          $display("FAIL blank_off p=%0d an=%b seg=%h want f 7f",
                   p, an, seg);
        end
      end
      if (p == 7) begin
        n_tests++;
        if ({an, seg} !== {4'b1101, 7'h3F}) begin
          n_fail++;
          $display("FAIL blank_resume an=%b seg=%h want 1101 3f",
                   an, seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    value_in = 4'b0110;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_pre_rst got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (m_idx == 2 && m_div == 1) hit = 1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_align slot2 not reached idx=%0d", m_idx);
    end
    reset = 1'b1;
    tick();
    exp_w = exp_q.pop_front();
    n_tests++;
    if ({disp_value, seg, an, dp} !== exp_w) begin
      n_fail++;
      $display("FAIL sb_rst_mid got %h want %h",
               {disp_value, seg, an, dp}, exp_w);
    end
    n_tests++;
    if ({seg, an, dp, disp_value} !== {7'h7F, 4'hF, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL rst_mid seg=%h an=%h dp=%b dv=%h want 7f f 1 0",
               seg, an, dp, disp_value);
    end
    reset = 1'b0;
    for (int p = 0; p < 10; p++) begin
      tick();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({disp_value, seg, an, dp} !== exp_w) begin
        n_fail++;
        $display("FAIL sb_post_rst got %h want %h",
                 {disp_value, seg, an, dp}, exp_w);
      end
      if (p < 4) begin
        n_tests++;
        if ({an, seg} !== {4'b1110, 7'h40}) begin
          n_fail++;
          $display("FAIL rst_restart p=%0d an=%b seg=%h want 1110 40",
                   p, an, seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_negative();
    test_minimum();
    test_glitch();
    test_scan_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
